// File: rtl/bit_index_decoder_if.sv
// Bit-index decoder bus: the index beat stream going in and the
// reconstructed word coming out, each with its own valid/ready pair.
interface bit_index_decoder_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) ();

  // Input beat stream
  logic [IDX_W-1:0] idx_i;
  logic             idx_none_i;
  logic             idx_last_i;
  logic             idx_val_i;
  logic             idx_ready_o;

  // Reconstructed word stream
  logic [WIDTH-1:0] data_o;
  logic [IDX_W:0]   data_cnt_o;
  logic             data_dup_o;
  logic             data_val_o;
  logic             data_ready_i;

  // Decoder side
  modport slave (
    input  idx_i, idx_none_i, idx_last_i, idx_val_i, data_ready_i,
    output idx_ready_o, data_o, data_cnt_o, data_dup_o, data_val_o
  );

  // Beat source / word sink side
  modport master (
    output idx_i, idx_none_i, idx_last_i, idx_val_i, data_ready_i,
    input  idx_ready_o, data_o, data_cnt_o, data_dup_o, data_val_o
  );

endinterface

// File: rtl/bit_index_decoder.sv
// Bit-index decoder: ORs one-hot(idx) over the beats of a packet, counts
// distinct set bits, flags repeated indices, and presents the finished
// word through a single output register with valid/ready handshake.
module bit_index_decoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  bit_index_decoder_if.slave   bus
);

  localparam int                 CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t            state_reg, state_next;

  logic [WIDTH-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              dup_reg, dup_next;

  logic [WIDTH-1:0]  data_reg, data_next;
  logic [CNT_W-1:0]  data_cnt_reg, data_cnt_next;
  logic              data_dup_reg, data_dup_next;
  logic              data_val_reg, data_val_next;

  logic              idx_ready;
  logic              accept;
  logic [WIDTH-1:0]  idx_onehot;
  logic              idx_hit;
  logic              idx_new;
  logic [WIDTH-1:0]  acc_upd;
  logic [CNT_W-1:0]  cnt_upd;
  logic              dup_upd;

  // The output register may only be refilled once its word is taken.
  assign idx_ready = !data_val_reg || bus.data_ready_i;
  assign accept    = bus.idx_val_i && idx_ready;

  // One-hot decode of the beat index; a "none" beat decodes to all zeros
  // so it contributes nothing to the accumulator, count or dup flag.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
    assign idx_onehot[gi] = !bus.idx_none_i && (bus.idx_i == IDX_W'(gi));
  end

  assign idx_hit = |(idx_onehot & acc_reg);
  assign idx_new = |(idx_onehot & ~acc_reg);
  assign acc_upd = acc_reg | idx_onehot;
  // Count only rises on a previously clear bit, so it tops out at WIDTH
  // exactly when every bit is set; the guard keeps it from ever wrapping.
  assign cnt_upd = (idx_new && (cnt_reg != CNT_MAX)) ? cnt_reg + CNT_ONE : cnt_reg;
  assign dup_upd = dup_reg | idx_hit;

  // Packet FSM next state: a last beat always closes the packet.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = bus.idx_last_i ? IDLE : ACCUM;
    end
  end

  // Accumulator and output register next values.
  always_comb begin
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    dup_next      = dup_reg;
    data_next     = data_reg;
    data_cnt_next = data_cnt_reg;
    data_dup_next = data_dup_reg;
    data_val_next = data_val_reg;

    if (data_val_reg && bus.data_ready_i) begin
      data_val_next = 1'b0;
    end

    if (accept) begin
      if (bus.idx_last_i) begin
        // Final beat's contribution goes straight to the output and the
        // accumulator restarts empty for the following packet.
        data_next     = acc_upd;
        data_cnt_next = cnt_upd;
        data_dup_next = dup_upd;
        data_val_next = 1'b1;
        acc_next      = '0;
        cnt_next      = '0;
        dup_next      = 1'b0;
      end else begin
        acc_next = acc_upd;
        cnt_next = cnt_upd;
        dup_next = dup_upd;
      end
    end
  end

  // State register; reset discards any partial packet and pending word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      dup_reg      <= 1'b0;
      data_reg     <= '0;
      data_cnt_reg <= '0;
      data_dup_reg <= 1'b0;
      data_val_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      dup_reg      <= dup_next;
      data_reg     <= data_next;
      data_cnt_reg <= data_cnt_next;
      data_dup_reg <= data_dup_next;
      data_val_reg <= data_val_next;
    end
  end

  assign bus.idx_ready_o = idx_ready;
  assign bus.data_o      = data_reg;
  assign bus.data_cnt_o  = data_cnt_reg;
  assign bus.data_dup_o  = data_dup_reg;
  assign bus.data_val_o  = data_val_reg;

endmodule

// File: tb/tb_bit_index_decoder.sv
// Bench for bit_index_decoder (WIDTH=16): table of packets, hand-written
// hold / reset sequences, and random packets under backpressure, all
// checked through an expected-word queue.
module tb_bit_index_decoder;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  bit_index_decoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  bit_index_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  c;
    logic        dup;
  } exp_t;

  typedef struct packed {
    logic [2:0]  nb;      // beats in packet
    logic [15:0] idxs;    // beat k index at idxs[4k+:4]
    logic [3:0]  none_m;  // beat k is a none beat
    exp_t        e;
  } vec_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          bp_mode = 0;   // 0: ready=1, 1: random, 2: driven by hand
  logic [15:0] acc_m;
  logic        dup_m;
  exp_t        last_exp;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Offer one beat and hold it until accepted; update the OR-model.
  task automatic beat(input logic [3:0] idx, input logic none, input logic last);
    int waited = 0;
    bus.idx_i      = idx;
    bus.idx_none_i = none;
    bus.idx_last_i = last;
    bus.idx_val_i  = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.idx_ready_o) break;
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: ready 0 for %0d cycles, want 1", waited);
        break;
      end
    end
    if (!none) begin
      if (acc_m[idx]) dup_m = 1'b1;
      acc_m[idx] = 1'b1;
    end
    if (last) begin
      last_exp = '{acc_m, 5'($countones(acc_m)), dup_m};
      acc_m    = '0;
      dup_m    = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Word monitor: pop and compare on every output handshake.
  always @(negedge clk) begin : monitor
    exp_t got;
    exp_t e;
    if (!srst && bus.data_val_o && bus.data_ready_i) begin
      got = '{bus.data_o, bus.data_cnt_o, bus.data_dup_o};
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got word %h, want none", got.d);
      end else begin
        e = sb_q.pop_front();
        $display("word d=%h cnt=%0d dup=%0d (want d=%h cnt=%0d dup=%0d)",
                 got.d, got.c, got.dup, e.d, e.c, e.dup);
        check("sb_word", {10'b0, got}, {10'b0, e});
      end
    end
  end

  // Downstream backpressure generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 0) bus.data_ready_i = 1'b1;
      else if (bp_mode == 1) bus.data_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation ran too long, want finish");
    $fatal(1);
  end

  // Check that a just-closed packet appears one cycle after its last beat.
  task automatic latency_check(input exp_t e);
    @(negedge clk);
    check("lat_val",  32'(bus.data_val_o), 32'd1);
    check("lat_data", 32'(bus.data_o), 32'(e.d));
    check("lat_cnt",  32'(bus.data_cnt_o), 32'(e.c));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    exp_t e;
    srst              = 1'b1;
    bus.idx_i         = '0;
    bus.idx_none_i    = 1'b0;
    bus.idx_last_i    = 1'b0;
    bus.idx_val_i     = 1'b0;
    bus.data_ready_i  = 1'b1;
    acc_m             = '0;
    dup_m             = 1'b0;

    vecs[0] = '{3'd3, 16'h0F93, 4'b0000, '{16'h8208, 5'd3, 1'b0}};
    vecs[1] = '{3'd2, 16'h0055, 4'b0000, '{16'h0020, 5'd1, 1'b1}};
    vecs[2] = '{3'd1, 16'h0000, 4'b0001, '{16'h0000, 5'd0, 1'b0}};
    vecs[3] = '{3'd3, 16'h0000, 4'b0010, '{16'h0001, 5'd1, 1'b1}};
    vecs[4] = '{3'd4, 16'h8421, 4'b0000, '{16'h0116, 5'd4, 1'b0}};
    vecs[5] = '{3'd2, 16'h0070, 4'b0001, '{16'h0080, 5'd1, 1'b0}};

    // Reset state, with a beat offered that must be ignored.
    bus.idx_val_i  = 1'b1;
    bus.idx_last_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.idx_ready_o), 32'd1);
    check("rst_val",   32'(bus.data_val_o), 32'd0);
    check("rst_data",  32'(bus.data_o), 32'd0);
    check("rst_cnt",   32'(bus.data_cnt_o), 32'd0);
    check("rst_dup",   32'(bus.data_dup_o), 32'd0);
    @(posedge clk);
    #1;
    srst          = 1'b0;
    bus.idx_val_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.idx_ready_o), 32'd1);
    check("post_rst_val",   32'(bus.data_val_o), 32'd0);
    @(posedge clk);
    #1;

    // Table-driven packets.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < int'(vecs[i].nb); k++) begin
        beat(vecs[i].idxs[4*k +: 4], vecs[i].none_m[k], k == int'(vecs[i].nb) - 1);
      end
      bus.idx_val_i = 1'b0;
      sb_q.push_back(vecs[i].e);
      latency_check(vecs[i].e);
    end

    // All sixteen bits, then the same plus one duplicate beyond WIDTH.
    for (int k = 0; k < 16; k++) beat(4'(k), 1'b0, k == 15);
    bus.idx_val_i = 1'b0;
    e = '{16'hFFFF, 5'd16, 1'b0};
    sb_q.push_back(e);
    latency_check(e);
    for (int k = 0; k < 16; k++) beat(4'(k), 1'b0, 1'b0);
    beat(4'd3, 1'b0, 1'b1);
    bus.idx_val_i = 1'b0;
    e = '{16'hFFFF, 5'd16, 1'b1};
    sb_q.push_back(e);
    latency_check(e);

    // Held output: ready drops, offered beats wait, then back-to-back load.
    bp_mode          = 2;
    bus.data_ready_i = 1'b0;
    beat(4'd10, 1'b0, 1'b1);
    sb_q.push_back('{16'h0400, 5'd1, 1'b0});
    bus.idx_i      = 4'd6;
    bus.idx_none_i = 1'b0;
    bus.idx_last_i = 1'b1;
    bus.idx_val_i  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_ready", 32'(bus.idx_ready_o), 32'd0);
      check("hold_data",  32'(bus.data_o), 32'h0400);
    end
    @(posedge clk);
    #1;
    bus.data_ready_i = 1'b1;
    sb_q.push_back('{16'h0040, 5'd1, 1'b0});
    @(negedge clk);
    check("release_ready", 32'(bus.idx_ready_o), 32'd1);
    @(posedge clk);
    #1;
    bus.idx_val_i = 1'b0;
    @(negedge clk);
    check("b2b_val",  32'(bus.data_val_o), 32'd1);
    check("b2b_data", 32'(bus.data_o), 32'h0040);
    @(posedge clk);
    #1;
    bp_mode = 0;

    // Reset in the middle of a packet discards it.
    beat(4'd2, 1'b0, 1'b0);
    beat(4'd7, 1'b0, 1'b0);
    bus.idx_val_i = 1'b0;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst  = 1'b0;
    acc_m = '0;
    dup_m = 1'b0;
    @(negedge clk);
    check("discard_val", 32'(bus.data_val_o), 32'd0);
    @(posedge clk);
    #1;
    beat(4'd4, 1'b0, 1'b1);
    bus.idx_val_i = 1'b0;
    e = '{16'h0010, 5'd1, 1'b0};
    sb_q.push_back(e);
    latency_check(e);

    // Random packets under random backpressure, checked against the model.
    bp_mode = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        beat(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), k == len - 1);
      end
      sb_q.push_back(last_exp);
      if ($urandom_range(0, 3) == 0) begin
        bus.idx_val_i = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.idx_val_i = 1'b0;
    bp_mode = 0;
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge clk);
    check("drain_left", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("end_val", 32'(bus.data_val_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_index_decoder.md
BIT_INDEX_DECODER -- requirements
Module: bit_index_decoder

Interface
REQ-001 Parameter: WIDTH, default 16, width of the reconstructed data word; legal values are powers of two, 4..64.
REQ-002 Parameter: IDX_W, default $clog2(WIDTH), width of a bit index.
REQ-003 Port: clk_i  input  1  single clock; all logic is on its rising edge.
REQ-004 Port: srst_i  input  1  reset, synchronous and active-high.
REQ-005 Port: idx_i  input  IDX_W  bit index of one set bit; 0 = LSB.
REQ-006 Port: idx_none_i  input  1  beat carries no index; idx_i is ignored.
REQ-007 Port: idx_last_i  input  1  marks the final beat of a packet.
REQ-008 Port: idx_val_i  input  1  input beat valid.
REQ-009 Port: idx_ready_o  output  1  block can accept an input beat.
REQ-010 Port: data_o  output  WIDTH  reconstructed word (OR of one-hot(idx) over the packet).
REQ-011 Port: data_cnt_o  output  IDX_W+1  number of distinct bits set in data_o.
REQ-012 Port: data_dup_o  output  1  packet contained at least one repeated index.
REQ-013 Port: data_val_o  output  1  data_o, data_cnt_o and data_dup_o are valid.
REQ-014 Port: data_ready_i  input  1  downstream accepts the output word.

Function
REQ-015 An input beat SHALL be accepted only on a cycle with idx_val_i & idx_ready_o; all other cycles leave accumulator state unchanged.
REQ-016 idx_ready_o SHALL equal !data_val_o | data_ready_i (combinational), so the output register is never overwritten before it is consumed.
REQ-017 The accumulator FSM SHALL have two states: IDLE (accumulator empty) and ACCUM (>=1 beat accepted, no last yet).
REQ-018 IDLE->ACCUM on an accepted beat with idx_last_i=0; ACCUM->IDLE or IDLE->IDLE on an accepted beat with idx_last_i=1; otherwise the state holds.
REQ-019 On each accepted beat with idx_none_i=0, acc SHALL be ORed with one-hot(idx_i); if acc[idx_i] was already 1, the dup flag SHALL be set and the count SHALL be unchanged; otherwise the count SHALL increment by 1.
REQ-020 On an accepted beat with idx_none_i=1, acc and count SHALL be unchanged, but idx_last_i SHALL still be honoured.
REQ-021 On an accepted last beat, the final acc/count/dup (including that beat's contribution) SHALL load into data_o/data_cnt_o/data_dup_o with data_val_o=1 on the next cycle (latency 1); acc, count and dup SHALL clear in the same cycle.
REQ-022 data_val_o SHALL hold with data_o, data_cnt_o and data_dup_o stable until a cycle with data_val_o & data_ready_i; it SHALL then deassert on the next cycle unless a new last beat is accepted in that same cycle, in which case the new packet loads (back-to-back, no bubble).
REQ-023 A single-beat packet (IDLE with last=1) SHALL be legal; a packet of only idx_none_i beats SHALL produce data_o=0, data_cnt_o=0.
REQ-024 data_cnt_o SHALL saturate at WIDTH (reached only when all bits are set); it SHALL never wrap.
REQ-025 Packets of any length SHALL be supported; beats beyond WIDTH can only be duplicates or none and SHALL update only the dup flag.
REQ-026 Sustained throughput SHALL be one accepted beat per cycle while data_ready_i=1.

Reset
REQ-027 While srst_i=1 at a clock edge: state=IDLE, acc=0, count=0, dup=0, data_o=0, data_cnt_o=0, data_dup_o=0, data_val_o=0.
REQ-028 Reset SHALL take priority over any simultaneous beat or output handshake; a partially accumulated packet SHALL be discarded.
REQ-029 idx_ready_o SHALL be 1 during and after reset (because data_val_o=0).

Verification
REQ-030 WIDTH=16; beats idx 3,9,15(last) back-to-back -> one cycle after the last beat: data_o=16'h8208, data_cnt_o=3, data_dup_o=0, data_val_o=1.
REQ-031 Beats 5,5(last) -> data_o=16'h0020, data_cnt_o=1, data_dup_o=1.
REQ-032 Single beat idx_none_i=1, last=1 -> data_o=0, data_cnt_o=0, data_val_o=1; beats 0..15 then last -> data_o=16'hFFFF, data_cnt_o=16.
REQ-033 Output held with data_ready_i=0 -> idx_ready_o=0; offered beats are not accepted; data_o stays stable; raising data_ready_i while a last beat is offered -> the new word appears the next cycle with data_val_o continuously 1.
REQ-034 Beats 2,7, then srst_i=1 for 1 cycle, then 4(last) -> data_o=16'h0010, data_cnt_o=1; no word is emitted for the discarded packet.
REQ-035 Random packets with random data_ready_i backpressure, checked against a scoreboard OR-model -> no lost, duplicated or corrupted words.
